friscv_m_ext_mc: RTL and testbench
==================================

Name: friscv_m_ext_mc

Overview:
- Parametrised, multi-cycle successor of the RV M-extension execution unit: executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, plus MULW/DIVW/DIVUW/REMW/REMUW when XLEN=64.
- Multiplier pipeline depth is configurable; the divider is an internal restoring radix-2 divider with RISC-V corner-case handling.
- Sits beside the ALU behind the control unit's instruction-bus handshake and writes back to the ISA register file.

Parameters:
- XLEN, 32, datapath width; 32 or 64. W-opcode decode exists only when 64.
- MUL_STAGES, 2, multiplier latency in cycles, 1..4.
- DIV_EARLY_OUT, 1, 1 = divide-by-zero and signed overflow complete in 1 cycle; 0 = full iteration count.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- srst  in  1  synchronous reset, active high
- m_valid  in  1  instruction valid
- m_ready  out  1  unit can accept
- m_instbus  in  INST_BUS_W  decoded instruction bus (opcode, funct3, funct7, rs1, rs2, rd fields)
- m_rs1_addr  out  5  rs1 field, combinational from m_instbus
- m_rs1_val  in  XLEN  rs1 value, same cycle
- m_rs2_addr  out  5  rs2 field, combinational
- m_rs2_val  in  XLEN  rs2 value, same cycle
- m_rd_wr  out  1  one-cycle write-back pulse
- m_rd_addr  out  5  destination register
- m_rd_val  out  XLEN  result
- m_rd_strb  out  XLEN/8  constant all ones

Behaviour:
- Reset (aresetn low, or srst at a clock edge): state IDLE; m_rd_wr=0, m_rd_addr=0, m_rd_val=0, all captured operands and counters cleared; m_ready=1 once out of reset.
- Reset mid-operation aborts the operation. No write-back occurs for it.
- Accept: m_valid & m_ready at an edge.
  - Captures rs1/rs2 values, funct3, rd, and the W flag (opcode==MULDIVW and XLEN==64).
  - For XLEN=32, MULDIVW is not decoded: instruction is consumed with no write-back.
- m_ready = (state==IDLE) | m_rd_wr. A new instruction may be accepted in the write-back cycle, so back-to-back operation is allowed.
- FSM:
  - IDLE -> MUL on accept of funct3[2]=0.
  - IDLE -> DIV on accept of funct3[2]=1.
  - MUL -> IDLE after MUL_STAGES cycles; the write-back pulse is in the last cycle.
  - DIV -> DONE after N iterations, where N=32 for W ops and XLEN otherwise.
  - DONE -> IDLE with the write-back pulse.
- Latency, counted in edges from the accept edge to the edge where m_rd_wr goes high:
  - Multiply: MUL_STAGES.
  - Divide: N+1.
  - Early-out (DIV_EARLY_OUT=1): 1.
- Multiply results:
  - MUL: low XLEN bits of signed x signed.
  - MULH: high XLEN bits of signed x signed.
  - MULHSU: high XLEN bits using an (XLEN+1)-bit sign/zero-extended product.
  - MULHU: high XLEN bits of unsigned x unsigned.
  - MULW: low 32 bits of rs1[31:0] x rs2[31:0], sign-extended to 64.
- Divide operands:
  - Signed ops take absolute values; the quotient sign is the XOR of the operand signs; the remainder takes the dividend sign.
  - W ops use the [31:0] operand bits; results are sign-extended from bit 31.
- Divide corner cases (at effective width):
  - Divisor 0: quotient all ones, remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend, remainder = 0.
- Output hold: m_rd_addr and m_rd_val stay registered and hold their last values when m_rd_wr=0.
- rd=x0: write-back still pulses with m_rd_addr=0; the register file discards it.
- m_valid while busy is ignored because m_ready=0. Upstream must hold the instruction stable until it is accepted.

Test Plan:
- XLEN=32, MUL_STAGES=2: MULH rs1=0x80000000, rs2=0x80000000 accepted at edge 0 -> m_rd_wr at edge 2, rd_val=0x40000000, m_ready low at edge 1.
- XLEN=32: MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE. MUL with the same operands -> 0x00000001.
- XLEN=32: DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> quotient 0xFFFFFFFD at edge 33. REM with the same operands -> 0xFFFFFFFF.
- XLEN=32, DIV_EARLY_OUT=1:
  - DIVU 5/0 -> 0xFFFFFFFF at edge 1.
  - REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- XLEN=64:
  - MULW rs1=0x7FFFFFFF, rs2=2 -> 0xFFFFFFFFFFFFFFFE.
  - DIVW rs1=0x00000000_80000000, rs2=1 -> 0xFFFFFFFF80000000 at edge 33.
- Back-to-back and reset:
  - A MUL accepted in the write-back cycle of a DIV -> both results pulse, with correct rd, in order.
  - aresetn asserted at mid-DIV (edge 10) -> no m_rd_wr, all outputs 0, m_ready=1 after release.

Source files
------------

// File: rtl/friscv_m_ext_mc.sv
// RISC-V M-extension execution unit: multi-cycle multiplier plus a restoring radix-2 divider
// with divide-by-zero / signed-overflow handling, single-pulse write-back to the register file.
module friscv_m_ext_mc #(
    parameter int XLEN          = 32,
    parameter int MUL_STAGES    = 2,
    parameter int DIV_EARLY_OUT = 1,
    parameter int INST_BUS_W    = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic [INST_BUS_W-1:0] m_instbus,
    output logic [4:0]            m_rs1_addr,
    input  logic [XLEN-1:0]       m_rs1_val,
    output logic [4:0]            m_rs2_addr,
    input  logic [XLEN-1:0]       m_rs2_val,
    output logic                  m_rd_wr,
    output logic [4:0]            m_rd_addr,
    output logic [XLEN-1:0]       m_rd_val,
    output logic [XLEN/8-1:0]     m_rd_strb,
    output logic [1:0]            dbg_state
);

    localparam logic [6:0]      OPCODE_MULDIVW = 7'b0111011;
    localparam int              CNT_W          = 7;
    localparam logic [CNT_W-1:0] MUL_LAST      = CNT_W'(MUL_STAGES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST_X    = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] DIV_LAST_W    = CNT_W'(31);
    localparam logic [XLEN-1:0] MIN_X          = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W          = {{(XLEN-31){1'b1}}, {31{1'b0}}};
    localparam int              W_SHIFT        = XLEN - 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Extends from bit 31 (sign or zero) when w is set; identity otherwise.
    function automatic logic [XLEN-1:0] ext_w(input logic [XLEN-1:0] v, input logic w,
                                              input logic sgn);
        logic [XLEN-1:0] r;
        r = v;
        if (w) begin
            for (int i = 32; i < XLEN; i++) r[i] = sgn & v[31];
        end
        return r;
    endfunction

    logic [6:0]      in_opcode;
    logic [2:0]      in_f3;
    logic [4:0]      in_rd;
    logic            in_w_op, in_w, in_drop, in_sgn, in_a_neg, in_b_neg, in_dz, in_ovf;
    logic            accept, wb_en;
    logic [XLEN-1:0] in_a_ext, in_b_ext, in_a_mag, in_b_mag;

    logic [XLEN-1:0]  op_a, op_b, div_q, quo_q, rem_q;
    logic [2:0]       f3_q;
    logic [4:0]       rd_q;
    logic             w_q, neg_quo_q, neg_rem_q, dz_q, ovf_q;
    logic [CNT_W-1:0] cnt_q;

    // Handshake: an instruction transfers on each aclk edge where m_valid & m_ready are both
    // high; upstream keeps m_instbus and the rs values stable until that edge.
    assign in_opcode  = m_instbus[6:0];
    assign in_rd      = m_instbus[11:7];
    assign in_f3      = m_instbus[14:12];
    assign m_rs1_addr = m_instbus[19:15];
    assign m_rs2_addr = m_instbus[24:20];
    assign in_w_op    = (in_opcode == OPCODE_MULDIVW);
    assign in_w       = in_w_op && (XLEN == 64);
    assign in_drop    = in_w_op && (XLEN != 64);
    assign m_ready    = (state == IDLE) || m_rd_wr;
    assign accept     = m_valid && m_ready;

    assign in_sgn   = ~in_f3[0];
    assign in_a_ext = ext_w(m_rs1_val, in_w, in_sgn);
    assign in_b_ext = ext_w(m_rs2_val, in_w, in_sgn);
    assign in_a_neg = in_sgn & in_a_ext[XLEN-1];
    assign in_b_neg = in_sgn & in_b_ext[XLEN-1];
    assign in_a_mag = in_a_neg ? -in_a_ext : in_a_ext;
    assign in_b_mag = in_b_neg ? -in_b_ext : in_b_ext;
    assign in_dz    = (in_b_ext == '0);
    assign in_ovf   = in_sgn && (in_a_ext == (in_w ? MIN_W : MIN_X)) && (in_b_ext == '1);

    // Multiplier: one (XLEN+1)-bit signed product covers all four signedness variants.
    logic                     a_sgn, b_sgn;
    logic signed [2*XLEN+1:0] a_x, b_x, prod;
    logic [XLEN-1:0]          mul_res;

    assign a_sgn = (f3_q[1:0] != 2'b11);
    assign b_sgn = ~f3_q[1];
    assign a_x   = {{(XLEN+2){a_sgn & op_a[XLEN-1]}}, op_a};
    assign b_x   = {{(XLEN+2){b_sgn & op_b[XLEN-1]}}, op_b};
    assign prod  = a_x * b_x;

    always_comb begin
        mul_res = prod[XLEN-1:0];
        if (w_q) mul_res = ext_w(prod[XLEN-1:0], 1'b1, 1'b1);
        else if (f3_q[1:0] != 2'b00) mul_res = prod[2*XLEN-1:XLEN];
    end

    // Restoring divider: W ops pre-shift the dividend so quo_q always shifts out MSB-first.
    logic [XLEN:0]   div_shift, div_diff;
    logic            div_ge;
    logic [XLEN-1:0] rem_nxt, quo_nxt, dvd_ext, div_quo, div_rem, div_res;

    assign div_shift = {rem_q, quo_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, div_q});
    assign div_diff  = div_shift - {1'b0, div_q};
    assign rem_nxt   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    assign quo_nxt   = {quo_q[XLEN-2:0], div_ge};
    assign dvd_ext   = ext_w(op_a, w_q, ~f3_q[0]);

    always_comb begin
        div_quo = neg_quo_q ? -quo_q : quo_q;
        div_rem = neg_rem_q ? -rem_q : rem_q;
        if (dz_q) begin
            div_quo = '1;
            div_rem = dvd_ext;
        end else if (ovf_q) begin
            div_quo = dvd_ext;
            div_rem = '0;
        end
        div_res = ext_w(f3_q[1] ? div_rem : div_quo, w_q, 1'b1);
    end

    always_comb begin
        state_nxt = state;
        wb_en     = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !in_drop) begin
                    if (!in_f3[2]) state_nxt = MUL;
                    else if ((DIV_EARLY_OUT != 0) && (in_dz || in_ovf)) state_nxt = DONE;
                    else state_nxt = DIV;
                end
            end
            MUL: begin
                if (cnt_q == MUL_LAST) begin
                    state_nxt = IDLE;
                    wb_en     = 1'b1;
                end
            end
            DIV: begin
                if (cnt_q == (w_q ? DIV_LAST_W : DIV_LAST_X)) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                wb_en     = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else if (srst) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_rd_wr <= 1'b0; m_rd_addr <= '0; m_rd_val <= '0;
            op_a <= '0; op_b <= '0; div_q <= '0; quo_q <= '0; rem_q <= '0;
            f3_q <= '0; rd_q <= '0; w_q <= 1'b0; cnt_q <= '0;
            neg_quo_q <= 1'b0; neg_rem_q <= 1'b0; dz_q <= 1'b0; ovf_q <= 1'b0;
        end else if (srst) begin
            m_rd_wr <= 1'b0; m_rd_addr <= '0; m_rd_val <= '0;
            op_a <= '0; op_b <= '0; div_q <= '0; quo_q <= '0; rem_q <= '0;
            f3_q <= '0; rd_q <= '0; w_q <= 1'b0; cnt_q <= '0;
            neg_quo_q <= 1'b0; neg_rem_q <= 1'b0; dz_q <= 1'b0; ovf_q <= 1'b0;
        end else begin
            m_rd_wr <= wb_en;
            if (wb_en) begin
                m_rd_addr <= rd_q;
                m_rd_val  <= (state == MUL) ? mul_res : div_res;
            end
            case (state)
                IDLE: begin
                    if (accept && !in_drop) begin
                        op_a      <= m_rs1_val;
                        op_b      <= m_rs2_val;
                        f3_q      <= in_f3;
                        rd_q      <= in_rd;
                        w_q       <= in_w;
                        cnt_q     <= '0;
                        div_q     <= in_b_mag;
                        quo_q     <= in_w ? (in_a_mag << W_SHIFT) : in_a_mag;
                        rem_q     <= '0;
                        neg_quo_q <= in_a_neg ^ in_b_neg;
                        neg_rem_q <= in_a_neg;
                        dz_q      <= in_dz;
                        ovf_q     <= in_ovf;
                    end
                end
                MUL: cnt_q <= cnt_q + 7'd1;
                DIV: begin
                    quo_q <= quo_nxt;
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q + 7'd1;
                end
                default: ;
            endcase
        end
    end

    assign m_rd_strb = '1;
    assign dbg_state = state;

    logic unused_bits;
    assign unused_bits = ^{m_instbus[INST_BUS_W-1:25], div_diff[XLEN], prod[2*XLEN+1:2*XLEN]};

endmodule

// File: tb/tb_friscv_m_ext_mc.sv
// Bench for friscv_m_ext_mc: an XLEN=32 and an XLEN=64 instance, scoreboarded write-backs,
// latency, corner-case, back-to-back and reset-abort scenarios.
module tb_friscv_m_ext_mc;

    localparam logic [6:0] OP_MULDIV  = 7'b0110011;
    localparam logic [6:0] OP_MULDIVW = 7'b0111011;
    localparam int         EW         = 69;

    logic        aclk = 1'b0;
    logic        aresetn, srst;

    logic        v32, rdy32, wr32;
    logic [31:0] ib32, a32, b32, val32;
    logic [4:0]  rs1a32, rs2a32, rd32;
    logic [3:0]  strb32;
    logic [1:0]  st32;

    logic        v64, rdy64, wr64;
    logic [31:0] ib64;
    logic [63:0] a64, b64, val64;
    logic [4:0]  rs1a64, rs2a64, rd64;
    logic [7:0]  strb64;
    logic [1:0]  st64;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    friscv_m_ext_mc #(.XLEN(32), .MUL_STAGES(2), .DIV_EARLY_OUT(1)) dut32 (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .m_valid(v32), .m_ready(rdy32), .m_instbus(ib32),
        .m_rs1_addr(rs1a32), .m_rs1_val(a32), .m_rs2_addr(rs2a32), .m_rs2_val(b32),
        .m_rd_wr(wr32), .m_rd_addr(rd32), .m_rd_val(val32), .m_rd_strb(strb32),
        .dbg_state(st32)
    );

    friscv_m_ext_mc #(.XLEN(64), .MUL_STAGES(2), .DIV_EARLY_OUT(1)) dut64 (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .m_valid(v64), .m_ready(rdy64), .m_instbus(ib64),
        .m_rs1_addr(rs1a64), .m_rs1_val(a64), .m_rs2_addr(rs2a64), .m_rs2_val(b64),
        .m_rd_wr(wr64), .m_rd_addr(rd64), .m_rd_val(val64), .m_rd_strb(strb64),
        .dbg_state(st64)
    );

    function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3,
                                            input logic [4:0] rd);
        return {7'b0000001, 5'd9, 5'd7, f3, rd, opc};
    endfunction

    // Drives one instruction so it is accepted at the next posedge; returns #1 after it.
    task automatic issue(input bit is64, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         input bit expect_wb, input logic [63:0] exp);
        @(negedge aclk);
        if (is64) begin
            v64 = 1'b1; ib64 = mk_inst(opc, f3, rd); a64 = a; b64 = b;
        end else begin
            v32 = 1'b1; ib32 = mk_inst(opc, f3, rd); a32 = a[31:0]; b32 = b[31:0];
        end
        if (expect_wb) exp_q.push_back(is64 ? {rd, exp} : {rd, 32'b0, exp[31:0]});
        @(posedge aclk);
        #1;
        v32 = 1'b0;
        v64 = 1'b0;
    endtask

    task automatic wait_wb(input bit is64, input string name, input int start, input int exp_lat);
        int n;
        bit seen;
        logic [EW-1:0] got, exp;
        n = start;
        seen = 0;
        while (!seen && n < start + 200) begin
            @(posedge aclk);
            #1;
            n++;
            seen = is64 ? wr64 : wr32;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: no write-back within %0d edges, required one at edge %0d",
                     name, n, exp_lat);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: write-back with empty expected queue", name);
        end else begin
            got = is64 ? {rd64, val64} : {rd32, 32'b0, val32};
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: rd/val got %h required %h", name, got, exp);
            end
            checks++;
            if (n != exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d edges required %0d", name, n, exp_lat);
            end
        end
    endtask

    task automatic no_wb(input bit is64, input string name, input int edges);
        bit seen;
        seen = 0;
        for (int i = 0; i < edges; i++) begin
            @(posedge aclk);
            #1;
            if (is64 ? wr64 : wr32) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL %s: got a write-back pulse, required none", name);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0; srst = 1'b0; v32 = 1'b0; v64 = 1'b0;
        ib32 = mk_inst(OP_MULDIV, 3'd0, 5'd1); ib64 = ib32;
        a32 = '0; b32 = '0; a64 = '0; b64 = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        checks++;
        if ({wr32, rd32, val32} !== 38'b0) begin
            errors++; $display("FAIL reset_out32: got %h required 0", {wr32, rd32, val32});
        end
        checks++;
        if ({wr64, rd64, val64} !== 70'b0) begin
            errors++; $display("FAIL reset_out64: got %h required 0", {wr64, rd64, val64});
        end
        checks++;
        if ({rdy32, rdy64} !== 2'b11) begin
            errors++; $display("FAIL reset_ready: got %b required 11", {rdy32, rdy64});
        end
        checks++;
        if ({st32, st64} !== 4'b0) begin
            errors++; $display("FAIL reset_state: got %b required 0000", {st32, st64});
        end
        checks++;
        if ({strb32, strb64} !== 12'hfff) begin
            errors++; $display("FAIL strb: got %h required fff", {strb32, strb64});
        end
        checks++;
        if ({rs1a32, rs2a32, rs1a64, rs2a64} !== {5'd7, 5'd9, 5'd7, 5'd9}) begin
            errors++; $display("FAIL rs_addr: got %0d %0d required 7 9", rs1a32, rs2a32);
        end
    endtask

    task automatic test_mul();
        logic [31:0] a, b, e;
        logic [2:0] f3;
        logic signed [63:0] pss, psu;
        logic [63:0] puu;
        issue(0, OP_MULDIV, 3'd1, 64'h80000000, 64'h80000000, 5'd3, 1, 64'h40000000);
        @(posedge aclk);
        #1;
        checks++;
        if (rdy32 !== 1'b0) begin
            errors++; $display("FAIL mulh_busy_ready: got %b required 0", rdy32);
        end
        wait_wb(0, "mulh", 1, 2);
        @(posedge aclk);
        #1;
        checks++;
        if ({wr32, rd32, val32} !== {1'b0, 5'd3, 32'h40000000}) begin
            errors++;
            $display("FAIL hold: got %h required %h", {wr32, rd32, val32}, {1'b0, 5'd3, 32'h40000000});
        end
        issue(0, OP_MULDIV, 3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd4, 1, 64'hFFFFFFFF);
        wait_wb(0, "mulhsu", 0, 2);
        issue(0, OP_MULDIV, 3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd5, 1, 64'hFFFFFFFE);
        wait_wb(0, "mulhu", 0, 2);
        issue(0, OP_MULDIV, 3'd0, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd0, 1, 64'h00000001);
        wait_wb(0, "mul_x0", 0, 2);
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom; f3 = 3'($urandom_range(0, 3));
            pss = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            psu = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
            puu = {32'b0, a} * {32'b0, b};
            case (f3)
                3'd0:    e = pss[31:0];
                3'd1:    e = pss[63:32];
                3'd2:    e = psu[63:32];
                default: e = puu[63:32];
            endcase
            issue(0, OP_MULDIV, f3, {32'b0, a}, {32'b0, b}, 5'(i + 10), 1, {32'b0, e});
            wait_wb(0, "mul_rand", 0, 2);
        end
    endtask

    task automatic test_div();
        logic [31:0] a, b, e;
        logic [2:0] f3;
        int sa, sb;
        issue(0, OP_MULDIV, 3'd4, 64'hFFFFFFF9, 64'd2, 5'd6, 1, 64'hFFFFFFFD);
        wait_wb(0, "div_neg7_2", 0, 33);
        issue(0, OP_MULDIV, 3'd6, 64'hFFFFFFF9, 64'd2, 5'd7, 1, 64'hFFFFFFFF);
        wait_wb(0, "rem_neg7_2", 0, 33);
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i < 4) ? 32'($urandom_range(1, 5000)) : $urandom;
            if (i[0]) b = -b;
            if (b == 32'd0) b = 32'd1;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
            f3 = 3'($urandom_range(4, 7));
            sa = a; sb = b;
            case (f3)
                3'd4:    e = 32'(sa / sb);
                3'd5:    e = a / b;
                3'd6:    e = 32'(sa % sb);
                default: e = a % b;
            endcase
            issue(0, OP_MULDIV, f3, {32'b0, a}, {32'b0, b}, 5'(i + 20), 1, {32'b0, e});
            wait_wb(0, "div_rand", 0, 33);
        end
    endtask

    task automatic test_div_corner();
        issue(0, OP_MULDIV, 3'd5, 64'd5, 64'd0, 5'd1, 1, 64'hFFFFFFFF);
        wait_wb(0, "divu_by0", 0, 1);
        issue(0, OP_MULDIV, 3'd7, 64'd5, 64'd0, 5'd2, 1, 64'd5);
        wait_wb(0, "remu_by0", 0, 1);
        issue(0, OP_MULDIV, 3'd4, 64'h80000000, 64'hFFFFFFFF, 5'd3, 1, 64'h80000000);
        wait_wb(0, "div_ovf", 0, 1);
        issue(0, OP_MULDIV, 3'd6, 64'h80000000, 64'hFFFFFFFF, 5'd4, 1, 64'd0);
        wait_wb(0, "rem_ovf", 0, 1);
        issue(0, OP_MULDIV, 3'd4, 64'hFFFFFFFD, 64'd0, 5'd5, 1, 64'hFFFFFFFF);
        wait_wb(0, "div_neg_by0", 0, 1);
        issue(0, OP_MULDIV, 3'd6, 64'hFFFFFFFD, 64'd0, 5'd6, 1, 64'hFFFFFFFD);
        wait_wb(0, "rem_neg_by0", 0, 1);
    endtask

    task automatic test_rv64();
        issue(1, OP_MULDIVW, 3'd0, 64'h7FFFFFFF, 64'd2, 5'd1, 1, 64'hFFFFFFFFFFFFFFFE);
        wait_wb(1, "mulw", 0, 2);
        issue(1, OP_MULDIVW, 3'd4, 64'h0000000080000000, 64'd1, 5'd2, 1, 64'hFFFFFFFF80000000);
        wait_wb(1, "divw", 0, 33);
        issue(1, OP_MULDIVW, 3'd5, 64'h5555555580000000, 64'd1, 5'd3, 1, 64'hFFFFFFFF80000000);
        wait_wb(1, "divuw", 0, 33);
        issue(1, OP_MULDIVW, 3'd6, 64'h0000000080000000, 64'h12345678FFFFFFFF, 5'd4, 1, 64'd0);
        wait_wb(1, "remw_ovf", 0, 1);
        issue(1, OP_MULDIV, 3'd5, 64'h0123456789ABCDEF, 64'h10, 5'd5, 1, 64'h00123456789ABCDE);
        wait_wb(1, "divu64", 0, 65);
        issue(1, OP_MULDIV, 3'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd6, 1,
              64'hFFFFFFFFFFFFFFFE);
        wait_wb(1, "mulhu64", 0, 2);
    endtask

    task automatic test_w_on_32();
        issue(0, OP_MULDIVW, 3'd0, 64'd5, 64'd6, 5'd4, 0, 64'd0);
        no_wb(0, "w_on_32", 6);
        checks++;
        if (rdy32 !== 1'b1) begin
            errors++; $display("FAIL w_on_32_ready: got %b required 1", rdy32);
        end
    endtask

    task automatic test_back_to_back();
        issue(0, OP_MULDIV, 3'd5, 64'd100, 64'd7, 5'd5, 1, 64'd14);
        wait_wb(0, "b2b_div", 0, 33);
        checks++;
        if (rdy32 !== 1'b1) begin
            errors++; $display("FAIL b2b_ready_in_wb: got %b required 1", rdy32);
        end
        issue(0, OP_MULDIV, 3'd0, 64'd12, 64'd13, 5'd6, 1, 64'd156);
        wait_wb(0, "b2b_mul", 0, 2);
    endtask

    task automatic test_srst();
        issue(0, OP_MULDIV, 3'd0, 64'd3, 64'd4, 5'd9, 0, 64'd0);
        @(negedge aclk);
        srst = 1'b1;
        @(posedge aclk);
        #1;
        srst = 1'b0;
        no_wb(0, "srst_abort", 5);
        checks++;
        if ({st32, rdy32} !== 3'b001) begin
            errors++; $display("FAIL srst_state: got %b required 001", {st32, rdy32});
        end
    endtask

    task automatic test_reset_mid_div();
        issue(0, OP_MULDIV, 3'd4, 64'd1000, 64'd3, 5'd8, 0, 64'd0);
        repeat (10) @(posedge aclk);
        #1;
        checks++;
        if (st32 !== 2'd2) begin
            errors++; $display("FAIL mid_div_state: got %0d required 2", st32);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if ({wr32, rd32, val32} !== 38'b0) begin
            errors++; $display("FAIL reset_mid_out: got %h required 0", {wr32, rd32, val32});
        end
        @(negedge aclk);
        aresetn = 1'b1;
        no_wb(0, "reset_abort", 40);
        checks++;
        if ({rdy32, rd32, val32} !== {1'b1, 37'b0}) begin
            errors++; $display("FAIL reset_after: got %h required %h", {rdy32, rd32, val32}, {1'b1, 37'b0});
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_corner();
        test_rv64();
        test_w_on_32();
        test_back_to_back();
        test_srst();
        test_reset_mid_div();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL leftover_expected: got %0d entries required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
